prog_loader_pit: RTL
====================

PROG_LOADER_PIT -- requirements
Module: prog_loader_pit

Interface
REQ-001 SHALL have reset rst, asynchronous, active-high; clock clk; all flops rising-edge clk.
REQ-002 Ports, in order:
- clk in 1: system clock.
- rst in 1: asynchronous active-high reset.
- load_start in 1: pulse; begins a new program load.
- in_valid in 1: load byte present.
- in_data in 8: program byte.
- in_last in 1: marks the final program byte.
- in_ready out 1: loader accepts a byte this cycle.
- cpu_addr in 8: processor fetch address.
- cpu_dout out 8: program byte for the processor.
- cpu_run out 1: processor released from hold; gates the processor's rst/enable.
- load_count out 8: bytes stored in the current or last load, 0..128.
- load_done out 1: last load finished cleanly.
- err_overflow out 1: last load exceeded 128 bytes.

Function
REQ-003 SHALL implement a registered FSM with states IDLE, LOAD, RUN and ERR.
REQ-004 IDLE: in_ready=0 and cpu_run=0.
- load_start moves to LOAD next cycle.
- Entering LOAD clears load_count, load_done and err_overflow.
REQ-005 LOAD: in_ready=1 combinationally from state.
- A beat is accepted when in_valid&in_ready are high on a clk edge.
- An accepted beat writes in_data at address load_count[6:0], and load_count increments by 1 on the same edge.
REQ-006 LOAD with an accepted beat where in_last=1: the byte is stored, then go to RUN and set load_done=1.
REQ-007 LOAD where the 128th byte is accepted with in_last=0: the byte is stored, load_count=128, then go to ERR and set err_overflow=1.
REQ-008 LOAD: load_start is ignored; in_valid=0 cycles hold all state (no timeout).
REQ-009 RUN: cpu_run=1 and in_ready=0.
- load_start moves to LOAD; cpu_run drops on that edge, so there is no cycle with cpu_run=1 during a load.
REQ-010 ERR: cpu_run=0 and in_ready=0.
- Only load_start leaves ERR, going to LOAD.
REQ-011 cpu_dout SHALL be combinational:
- cpu_addr[7]=1 gives 8'h00; the processor's data region is not served.
- cpu_addr[7]=0 and cpu_addr[6:0] < load_count gives the stored byte.
- Otherwise gives 8'hF0 (HLT), so an unloaded address halts the processor.
REQ-012 Simultaneous write and read at the same address in the same cycle: cpu_dout SHALL show the old content (or F0 if not yet counted); the new byte is visible from the next cycle.
REQ-013 load_count SHALL be 8 bits and saturate at 128; it never wraps.

Reset
REQ-014 rst SHALL immediately force state=IDLE, load_count=0, load_done=0, err_overflow=0, in_ready=0 and cpu_run=0, including mid-LOAD.
REQ-015 RAM array contents SHALL NOT be reset; REQ-011 masking with load_count=0 makes every fetch read 8'hF0 after reset.

Structure
REQ-016 A shared package prog_loader_pkg_pit SHALL hold:
- the state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, ERR=2'd3);
- PROG_DEPTH=128;
- OP_HLT=8'hF0;
- DATA_REGION_FILL=8'h00.
REQ-017 Storage SHALL be one sub-module, prog_ram_pit: 128x8, one synchronous write port, one asynchronous read port, no reset.
REQ-018 FSM, counter and read masking SHALL live in prog_loader_pit; no other sub-modules.

Verification
REQ-019 Reset mid-load:
- Stimulus: load_start, accept 3 bytes, assert rst.
- Required: in_ready=0, load_count=0, cpu_run=0; cpu_addr=0 reads F0.
REQ-020 Normal load:
- Stimulus: load_start, then 5 beats 8'h20,8'h80,8'h31,8'h81,8'h1F with in_last on the 5th.
- Required: load_done=1, cpu_run=1, load_count=5.
- Reads: addr 0..4 return the bytes; addr 5 returns F0; addr 8'h80 returns 00.
REQ-021 Backpressure:
- Stimulus: in_valid toggles 1,0,0,1 over a 2-byte load.
- Required: exactly 2 writes, load_count=2, no duplicates.
REQ-022 Overflow:
- Stimulus: 129 beats offered, in_last never set.
- Required: 128 stored, err_overflow=1, cpu_run=0, in_ready=0 after the 128th beat, load_count=128.
- Reload: load_start then a 1-byte load returns to RUN with err_overflow=0.
REQ-023 Reload while running:
- Stimulus: in RUN, pulse load_start.
- Required: cpu_run=0 on the next edge; load_count=0; all fetches read F0 until new bytes arrive.
REQ-024 Same-cycle write/read:
- Stimulus: cpu_addr=2 while byte 2 (8'h55) is written.
- Required: F0 that cycle, 8'h55 the next cycle.

Source files
------------

// File: rtl/prog_loader_pkg_pit.sv
// Shared definitions for the program loader: FSM encoding, store depth and
// the fill values served to the processor for unloaded or data addresses.
package prog_loader_pkg_pit;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int          PROG_DEPTH       = 128;
  localparam logic [7:0]  COUNT_MAX        = 8'(PROG_DEPTH);
  localparam logic [7:0]  OP_HLT           = 8'hF0;
  localparam logic [7:0]  DATA_REGION_FILL = 8'h00;

endpackage

// File: rtl/prog_ram_pit.sv
// 128x8 program store: one synchronous write port, one asynchronous read
// port, no reset (contents are hidden by the loader's count mask instead).
module prog_ram_pit
  import prog_loader_pkg_pit::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [PROG_DEPTH];

  // Write port: byte lands on the rising edge, so a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: combinational lookup.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/prog_loader_pit.sv
// Program loader: streams bytes into a 128x8 store, then releases the
// processor (cpu_run) to fetch them. Unloaded addresses read as HLT and the
// upper half of the address space reads as data-region fill.
//
// Handshake: a byte transfers on a rising clk edge exactly when in_valid and
// in_ready are both high. in_ready depends only on the FSM state (high in
// LOAD), never on in_valid; the source may hold in_valid low for any number
// of cycles and the loader simply waits.
module prog_loader_pit
  import prog_loader_pkg_pit::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [7:0] cpu_addr,
  output logic [7:0] cpu_dout,
  output logic       cpu_run,
  output logic [7:0] load_count,
  output logic       load_done,
  output logic       err_overflow
);

  // state is kept as a named enum so checkers can bind to it directly.
  state_t     state;
  state_t     state_nx;
  logic       accept;
  logic       enter_load;
  logic       at_last_slot;
  logic [7:0] ram_rd;

  assign accept       = in_valid & in_ready;
  assign at_last_slot = (load_count == COUNT_MAX - 8'd1);
  assign enter_load   = (state != ST_LOAD) && (state_nx == ST_LOAD);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load_start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        // in_last wins even on the 128th byte: a full, terminated load is clean.
        if (accept) begin
          if (in_last)           state_nx = ST_RUN;
          else if (at_last_slot) state_nx = ST_ERR;
        end
      end
      ST_RUN: begin
        cpu_run = 1'b1;
        if (load_start) state_nx = ST_LOAD;
      end
      ST_ERR: begin
        if (load_start) state_nx = ST_LOAD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Load counter and completion flags; cleared on every entry into LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count   <= 8'd0;
      load_done    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (enter_load) begin
      load_count   <= 8'd0;
      load_done    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (accept) begin
      if (load_count != COUNT_MAX) load_count <= load_count + 8'd1;
      if (in_last)           load_done    <= 1'b1;
      else if (at_last_slot) err_overflow <= 1'b1;
    end
  end

  // accept only occurs while load_count <= 127, so bits [6:0] address the store.
  prog_ram_pit u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (load_count[6:0]),
    .wr_data (in_data),
    .rd_addr (cpu_addr[6:0]),
    .rd_data (ram_rd)
  );

  // Fetch masking: data region, loaded bytes, otherwise HLT.
  always_comb begin
    cpu_dout = OP_HLT;
    if (cpu_addr[7])                              cpu_dout = DATA_REGION_FILL;
    else if ({1'b0, cpu_addr[6:0]} < load_count)  cpu_dout = ram_rd;
  end

endmodule
